// File: rtl/bitwise_reduce_stream_if.sv
// Stream bundle for bitwise_reduce_stream: operand beats in, frame result out.
// out_beats exists only when REDUCE_COUNT_EN is defined.
interface bitwise_reduce_stream_if #(
  parameter int WIDTH = 8,
  parameter int N     = 8
);
  logic [1:0]         mode;
  logic [N*WIDTH-1:0] I;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [WIDTH-1:0]   O;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
`ifdef REDUCE_COUNT_EN
  logic [7:0]         out_beats;

  modport master (
    output mode, I, in_valid, in_last, out_ready,
    input  in_ready, O, out_valid, busy, out_beats
  );

  modport slave (
    input  mode, I, in_valid, in_last, out_ready,
    output in_ready, O, out_valid, busy, out_beats
  );
`else
  modport master (
    output mode, I, in_valid, in_last, out_ready,
    input  in_ready, O, out_valid, busy
  );

  modport slave (
    input  mode, I, in_valid, in_last, out_ready,
    output in_ready, O, out_valid, busy
  );
`endif
endinterface

// File: rtl/bitwise_reduce_stream.sv
// Two-stage streaming OR/AND/XOR/NOR reducer folding N-word beats into one result per frame.
// Optional REDUCE_COUNT_EN adds a saturating per-frame beat count on out_beats.
module bitwise_reduce_stream #(
  parameter int WIDTH = 8,
  parameter int N     = 8
) (
  input logic                   CLK,
  input logic                   RESET,
  bitwise_reduce_stream_if.slave bus
);

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  logic             firstBeat_q;
  op_e              frameMode_q;
  logic             aValid_q;
  logic             aFirst_q;
  logic             aLast_q;
  op_e              aMode_q;
  logic [WIDTH-1:0] aRes_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] o_q;
  logic             outValid_q;
  logic             busy_q;

  op_e              beatMode;
  logic [WIDTH-1:0] beatRes;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] o_d;
  logic             bFree;
  logic             bConsume;
  logic             inReady;
  logic             accept;

  // Mode is latched on the first beat only; later beats reuse the frame mode.
  always_comb begin
    beatMode = firstBeat_q ? op_e'(bus.mode) : frameMode_q;
    beatRes  = bus.I[WIDTH-1:0];
    for (int k = 1; k < N; k++) begin
      case (beatMode)
        OP_AND:  beatRes = beatRes & bus.I[k*WIDTH +: WIDTH];
        OP_XOR:  beatRes = beatRes ^ bus.I[k*WIDTH +: WIDTH];
        default: beatRes = beatRes | bus.I[k*WIDTH +: WIDTH];
      endcase
    end
  end

  // Non-last beats may always fold; only a frame-closing beat needs O to be free.
  always_comb begin
    bFree    = !outValid_q || bus.out_ready;
    bConsume = aValid_q && (!aLast_q || bFree);
    inReady  = !aValid_q || bConsume;
    accept   = bus.in_valid && inReady;
  end

  always_comb begin
    acc_d = aRes_q;
    if (!aFirst_q) begin
      case (aMode_q)
        OP_AND:  acc_d = acc_q & aRes_q;
        OP_XOR:  acc_d = acc_q ^ aRes_q;
        default: acc_d = acc_q | aRes_q;
      endcase
    end
    o_d = (aMode_q == OP_NOR) ? ~acc_d : acc_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      firstBeat_q <= 1'b1;
      frameMode_q <= OP_OR;
      aValid_q    <= 1'b0;
      aFirst_q    <= 1'b0;
      aLast_q     <= 1'b0;
      aMode_q     <= OP_OR;
      aRes_q      <= '0;
      acc_q       <= '0;
      o_q         <= '0;
      outValid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (accept) begin
        aValid_q    <= 1'b1;
        aFirst_q    <= firstBeat_q;
        aLast_q     <= bus.in_last;
        aMode_q     <= beatMode;
        aRes_q      <= beatRes;
        firstBeat_q <= bus.in_last;
        frameMode_q <= beatMode;
      end else if (bConsume) begin
        aValid_q <= 1'b0;
      end

      if (bConsume) begin
        acc_q <= acc_d;
      end

      // A fresh result may replace O on the very edge the old one handshakes.
      if (bConsume && aLast_q) begin
        o_q        <= o_d;
        outValid_q <= 1'b1;
      end else if (bus.out_ready) begin
        outValid_q <= 1'b0;
      end

      if (bConsume && aLast_q) begin
        busy_q <= 1'b0;
      end
      if (accept && firstBeat_q) begin
        busy_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.O         = o_q;
  assign bus.out_valid = outValid_q;
  assign bus.busy      = busy_q;

`ifdef REDUCE_COUNT_EN
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [7:0] outBeats_q;

  always_comb begin
    if (aFirst_q) begin
      cnt_d = 8'd1;
    end else if (cnt_q == 8'hFF) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q      <= 8'd0;
      outBeats_q <= 8'd0;
    end else if (bConsume) begin
      cnt_q <= cnt_d;
      if (aLast_q) begin
        outBeats_q <= cnt_d;
      end
    end
  end

  assign bus.out_beats = outBeats_q;
`endif

endmodule

// File: tb/tb_bitwise_reduce_stream.sv
// Scoreboard bench for bitwise_reduce_stream: directed frames from the plan plus random frames.
// Define REDUCE_COUNT_EN to also exercise out_beats.
module tb_bitwise_reduce_stream;

  localparam int WIDTH = 8;
  localparam int N     = 8;

  typedef struct {
    logic [WIDTH-1:0] o;
    int               beats;
  } exp_t;

  logic CLK;
  logic RESET;
  int   nChecks;
  int   nPass;
  bit   randReady;
  exp_t sb[$];

  bitwise_reduce_stream_if #(.WIDTH(WIDTH), .N(N)) bus ();

  bitwise_reduce_stream #(.WIDTH(WIDTH), .N(N)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Results are compared whenever the DUT hands one off.
  always @(negedge CLK) begin
    if (!RESET && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedOut", {24'd0, bus.O}, 32'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sbResult", {24'd0, bus.O}, {24'd0, e.o});
`ifdef REDUCE_COUNT_EN
        checkOutput("sbBeats", {24'd0, bus.out_beats}, e.beats);
`endif
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (randReady) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic pushExp(input logic [WIDTH-1:0] o, input int beats);
    exp_t e;
    e.o     = o;
    e.beats = (beats > 255) ? 255 : beats;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic applyStimulus(input logic [N*WIDTH-1:0] data, input bit last, input logic [1:0] m);
    int t;
    bus.I        = data;
    bus.in_last  = last;
    bus.mode     = m;
    bus.in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge CLK);
      if (bus.in_ready) break;
      t++;
      if (t > 1000) begin
        checkOutput("acceptTimeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int t;
    t = 0;
    while ((sb.size() != 0 || bus.out_valid) && t < 2000) begin
      @(posedge CLK);
      t++;
    end
    #1;
    checkOutput("drain", sb.size(), 32'd0);
  endtask

  // Independent model: count ones per bit position over the whole frame.
  task automatic randomFrame(input int len, input logic [1:0] m);
    int               ones[WIDTH];
    logic [N*WIDTH-1:0] d;
    logic [WIDTH-1:0]   o;
    for (int b = 0; b < WIDTH; b++) ones[b] = 0;
    for (int i = 0; i < len; i++) begin
      d = {$urandom, $urandom};
      if (m == 2'b01) d = d | {$urandom, $urandom} | {$urandom, $urandom};
      if (m == 2'b11 && $urandom_range(0, 1) == 1) d = '0;
      for (int k = 0; k < N; k++)
        for (int b = 0; b < WIDTH; b++)
          ones[b] += int'(d[k*WIDTH+b]);
      applyStimulus(d, i == len - 1, (i == 0) ? m : 2'($urandom_range(0, 3)));
    end
    for (int b = 0; b < WIDTH; b++) begin
      case (m)
        2'b00:   o[b] = (ones[b] != 0);
        2'b01:   o[b] = (ones[b] == N * len);
        2'b10:   o[b] = ones[b][0];
        default: o[b] = (ones[b] == 0);
      endcase
    end
    pushExp(o, len);
  endtask

  initial begin
    logic [N*WIDTH-1:0] d;
    nChecks       = 0;
    nPass         = 0;
    randReady     = 1'b0;
    RESET         = 1'b1;
    bus.mode      = 2'b00;
    bus.I         = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;

    checkOutput("rstInReady", bus.in_ready, 1);
    checkOutput("rstOutValid", bus.out_valid, 0);
    checkOutput("rstO", bus.O, 0);
    checkOutput("rstBusy", bus.busy, 0);
`ifdef REDUCE_COUNT_EN
    checkOutput("rstBeats", bus.out_beats, 0);
`endif

    // OR of one-hot words, with latency and busy pulse.
    d = 64'h8040201008040201;
    pushExp(8'hFF, 1);
    applyStimulus(d, 1'b1, 2'b00);
    checkOutput("latEarly", bus.out_valid, 0);
    checkOutput("busyOn", bus.busy, 1);
    @(posedge CLK);
    #1;
    checkOutput("latValid", bus.out_valid, 1);
    checkOutput("orResult", bus.O, 8'hFF);
    checkOutput("busyOff", bus.busy, 0);
    waitDrain();

    // AND over two beats; mode flips to XOR mid-frame and must be ignored.
    pushExp(8'h30, 2);
    applyStimulus(64'hFFFFFFFFF0FFFFFF, 1'b0, 2'b01);
    applyStimulus({8{8'h3F}}, 1'b1, 2'b10);
    // XOR over three beats, then NOR of an all-zero beat.
    pushExp(8'h00, 3);
    applyStimulus(64'h5A, 1'b0, 2'b10);
    applyStimulus(64'hA5, 1'b0, 2'b01);
    applyStimulus(64'hFF, 1'b1, 2'b00);
    pushExp(8'hFF, 1);
    applyStimulus(64'h0, 1'b1, 2'b11);
    waitDrain();

    // Backpressure: O pending, a 4-beat frame folds and its last beat stalls in A.
    bus.out_ready = 1'b0;
    pushExp(8'h0C, 1);
    applyStimulus(64'h0C, 1'b1, 2'b00);
    @(posedge CLK);
    #1;
    checkOutput("bpPending", bus.out_valid, 1);
    pushExp(8'h0F, 4);
    applyStimulus(64'h01, 1'b0, 2'b00);
    applyStimulus(64'h02, 1'b0, 2'b00);
    applyStimulus(64'h04, 1'b0, 2'b00);
    applyStimulus(64'h08, 1'b1, 2'b00);
    checkOutput("bpStallReady", bus.in_ready, 0);
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("bpStillReady", bus.in_ready, 0);
    checkOutput("bpHoldO", bus.O, 8'h0C);
    bus.out_ready = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("bpSwapValid", bus.out_valid, 1);
    checkOutput("bpSwapO", bus.O, 8'h0F);
    waitDrain();

    // Reset with a pending O and a half-finished frame: both are discarded.
    bus.out_ready = 1'b0;
    applyStimulus(64'h30, 1'b1, 2'b00);
    applyStimulus(64'h40, 1'b0, 2'b00);
    applyStimulus(64'h80, 1'b0, 2'b00);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    checkOutput("midRstValid", bus.out_valid, 0);
    checkOutput("midRstBusy", bus.busy, 0);
    checkOutput("midRstReady", bus.in_ready, 1);
    checkOutput("midRstO", bus.O, 0);
    bus.out_ready = 1'b1;
    pushExp(8'h0C, 1);
    applyStimulus(64'h0C, 1'b1, 2'b00);
    waitDrain();

    // Random frames under random consumer backpressure.
    randReady = 1'b1;
    for (int f = 0; f < 25; f++) begin
      randomFrame($urandom_range(1, 4), 2'($urandom_range(0, 3)));
    end
    randReady = 1'b0;
    @(posedge CLK);
    #1;
    bus.out_ready = 1'b1;
    waitDrain();

`ifdef REDUCE_COUNT_EN
    // Beat count saturates on a long frame and restarts on the next one.
    pushExp(8'hFF, 300);
    for (int i = 0; i < 300; i++) begin
      d = 64'(1) << (i % 8);
      applyStimulus(d, i == 299, 2'b00);
    end
    pushExp(8'h0C, 1);
    applyStimulus(64'h0C, 1'b1, 2'b00);
    waitDrain();
`endif

    repeat (2) @(posedge CLK);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
